// File: rtl/rx_serial_comando.sv
// rx_serial_comando: 8N1 serial receiver for position-command bytes.
// Bit 7 of each valid byte selects command (1) or data (0); bits 6:0 are the
// payload. A bad stop bit raises erroParada and leaves the last good byte alone.
module rx_serial_comando #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    output logic [6:0] dados,
    output logic       comando,
    output logic       fimRecepcao,
    output logic       erroParada,
    output logic [3:0] dbEstado
);

    // Timer is just wide enough to count 0..CLKS_PER_BIT-1
    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerW-1:0] BitLast  = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [TimerW-1:0] HalfLast = TimerW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [3:0] {
        StInicial = 4'b0000,
        StEspera  = 4'b0001,
        StInicio  = 4'b0010,
        StDados   = 4'b0011,
        StParada  = 4'b0100,
        StFim     = 4'b0101,
        StErro    = 4'b0110
    } estado_t;

    estado_t           estado;
    logic              rx_meta;
    logic              rx_s;
    logic [TimerW-1:0] timer;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with bit timer, shift register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= StInicial;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            dados       <= '0;
            comando     <= 1'b0;
            fimRecepcao <= 1'b0;
            erroParada  <= 1'b0;
        end else begin
            fimRecepcao <= 1'b0;
            case (estado)
                StInicial: begin
                    estado <= StEspera;
                end
                StEspera: begin
                    if (!rx_s) begin
                        estado  <= StInicio;
                        timer   <= '0;
                        bit_idx <= '0;
                    end
                end
                StInicio: begin
                    // Re-check the line at mid start bit to reject glitches
                    if (timer == HalfLast) begin
                        timer <= '0;
                        if (!rx_s) begin
                            estado     <= StDados;
                            erroParada <= 1'b0;
                        end else begin
                            estado <= StEspera;
                        end
                    end else begin
                        timer <= timer + TimerW'(1);
                    end
                end
                StDados: begin
                    if (timer == BitLast) begin
                        timer          <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            estado <= StParada;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + TimerW'(1);
                    end
                end
                StParada: begin
                    if (timer == BitLast) begin
                        timer <= '0;
                        if (rx_s) begin
                            estado      <= StFim;
                            dados       <= shift[6:0];
                            comando     <= shift[7];
                            fimRecepcao <= 1'b1;
                        end else begin
                            estado     <= StErro;
                            erroParada <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TimerW'(1);
                    end
                end
                StFim: begin
                    estado <= StEspera;
                end
                StErro: begin
                    // Wait for the line to return idle before hunting again
                    if (rx_s) begin
                        estado <= StEspera;
                    end
                end
                default: begin
                    estado <= StInicial;
                end
            endcase
        end
    end

    // Debug state code; unknown encodings show as 1111
    always_comb begin
        dbEstado = 4'b1111;
        case (estado)
            StInicial: dbEstado = 4'b0000;
            StEspera:  dbEstado = 4'b0001;
            StInicio:  dbEstado = 4'b0010;
            StDados:   dbEstado = 4'b0011;
            StParada:  dbEstado = 4'b0100;
            StFim:     dbEstado = 4'b0101;
            StErro:    dbEstado = 4'b0110;
            default:   dbEstado = 4'b1111;
        endcase
    end

endmodule

// File: tb/tb_rx_serial_comando.sv
// Self-checking bench for rx_serial_comando with a frame-level reference model.
module tb_rx_serial_comando;

    localparam int unsigned N   = 8;
    localparam int          Lat = 2 + N / 2 + 9 * N + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       RX    = 1'b1;
    logic [6:0] dados;
    logic       comando;
    logic       fimRecepcao;
    logic       erroParada;
    logic [3:0] dbEstado;

    rx_serial_comando #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .RX         (RX),
        .dados      (dados),
        .comando    (comando),
        .fimRecepcao(fimRecepcao),
        .erroParada (erroParada),
        .dbEstado   (dbEstado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         due;
        logic [7:0] b;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] last_byte      = 8'h00;
    int         last_pulse_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: each valid frame must produce one pulse near its due cycle,
    // and the byte outputs always show the most recent valid frame.
    always @(negedge clock) begin
        if (reset) begin
            expq.delete();
            last_byte = 8'h00;
        end else begin
            if (fimRecepcao) begin
                if (expq.size() == 0) begin
                    check("pulse_without_frame", fimRecepcao, 1'b0);
                end else begin
                    check("pulse_window",
                          (cyc >= expq[0].due - 1) && (cyc <= expq[0].due + 1), 1'b1);
                    last_byte      = expq[0].b;
                    last_pulse_cyc = cyc;
                    void'(expq.pop_front());
                end
            end else if (expq.size() != 0 && cyc > expq[0].due + 1) begin
                check("missed_pulse", fimRecepcao, 1'b1);
                void'(expq.pop_front());
            end
            check("dados_model", dados, last_byte[6:0]);
            check("comando_model", comando, last_byte[7]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one 8N1 frame starting now; stop level and length are selectable.
    task automatic drive_frame(input logic [7:0] b, input logic stop_val, input int stop_cycles,
                               input bit expect_ok);
        exp_t e;
        RX = 1'b0;
        if (expect_ok) begin
            e.due = cyc + Lat;
            e.b   = b;
            expq.push_back(e);
        end
        tick(N);
        check("erro_clear_on_start", erroParada, 1'b0);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(N);
        end
        RX = stop_val;
        tick(stop_cycles);
        RX = 1'b1;
    endtask

    task automatic glitch(input int len);
        RX = 1'b0;
        tick(len);
        RX = 1'b1;
        tick(12);
    endtask

    initial begin
        int         start41;
        logic [7:0] rb;
        int         r;
        int         w;

        // Reset behaviour
        reset = 1'b1;
        RX    = 1'b1;
        tick(3);
        check("rst_dbEstado", dbEstado, 4'b0000);
        check("rst_dados", dados, 7'b0000000);
        check("rst_comando", comando, 1'b0);
        check("rst_fim", fimRecepcao, 1'b0);
        check("rst_erro", erroParada, 1'b0);
        reset = 1'b0;
        check("post_rst_inicial", dbEstado, 4'b0000);
        tick(1);
        check("post_rst_espera", dbEstado, 4'b0001);
        tick(2);

        // Single data byte 0x41
        start41 = cyc;
        drive_frame(8'h41, 1'b1, N, 1'b1);
        tick(3);
        check("b41_dados", dados, 7'b1000001);
        check("b41_comando", comando, 1'b0);
        check("b41_erro", erroParada, 1'b0);
        check("b41_latency", (last_pulse_cyc - start41 >= 78) && (last_pulse_cyc - start41 <= 80),
              1'b1);

        // Back-to-back 0xC5 then 0x12
        drive_frame(8'hC5, 1'b1, N, 1'b1);
        check("bC5_dados", dados, 7'b1000101);
        check("bC5_comando", comando, 1'b1);
        drive_frame(8'h12, 1'b1, N, 1'b1);
        tick(2);
        check("b12_dados", dados, 7'b0010010);
        check("b12_comando", comando, 1'b0);

        // Two-cycle glitch is rejected
        glitch(2);
        check("glitch_dados", dados, 7'b0010010);
        check("glitch_espera", dbEstado, 4'b0001);

        // Bad stop bit, then recovery with 0x55
        drive_frame(8'h41, 1'b1, N, 1'b1);
        tick(4);
        drive_frame(8'h33, 1'b0, 20, 1'b0);
        check("err_state", dbEstado, 4'b0110);
        check("err_flag", erroParada, 1'b1);
        tick(6);
        check("err_back_espera", dbEstado, 4'b0001);
        check("err_flag_held", erroParada, 1'b1);
        check("err_dados_kept", dados, 7'b1000001);
        check("err_comando_kept", comando, 1'b0);
        drive_frame(8'h55, 1'b1, N, 1'b1);
        tick(3);
        check("b55_dados", dados, 7'b1010101);
        check("b55_comando", comando, 1'b0);
        check("b55_erro", erroParada, 1'b0);

        // Reset during data bit 4 of 0x7F
        tick(4);
        RX = 1'b0;
        tick(N);
        for (int i = 0; i < 4; i++) begin
            RX = 1'b1;
            tick(N);
        end
        tick(N / 2);
        reset = 1'b1;
        RX    = 1'b1;
        tick(2);
        reset = 1'b0;
        check("midrst_dados", dados, 7'b0000000);
        check("midrst_comando", comando, 1'b0);
        check("midrst_state", dbEstado, 4'b0000);
        tick(2);
        drive_frame(8'h01, 1'b1, N, 1'b1);
        tick(3);
        check("b01_dados", dados, 7'b0000001);
        check("b01_comando", comando, 1'b0);

        // Randomized traffic: valid frames, back-to-back runs, glitches, stop errors
        for (int k = 0; k < 40; k++) begin
            r  = int'($urandom_range(0, 9));
            rb = 8'($urandom);
            if (r == 0) begin
                glitch(int'($urandom_range(1, 3)));
            end else if (r == 1) begin
                drive_frame(rb, 1'b0, int'($urandom_range(N, 3 * N)), 1'b0);
                tick(4);
            end else begin
                drive_frame(rb, 1'b1, N, 1'b1);
                if (r > 4) tick(int'($urandom_range(1, 6)));
            end
        end

        w = 0;
        while (expq.size() != 0 && w < 200) begin
            tick(1);
            w++;
        end
        tick(5);
        check("final_espera", dbEstado, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
